// File: rtl/dual_execute_stage.sv
// Dual-issue execute stage: two ALU slots, EX/MEM register and an iterative slot-0 multiplier.
// Optional macro MULHU_EN enables op 0xB (upper half of the unsigned product) in slot 0.
package dual_execute_stage_pkg;

   localparam logic [3:0] OP_ADD   = 4'h0;
   localparam logic [3:0] OP_SUB   = 4'h1;
   localparam logic [3:0] OP_AND   = 4'h2;
   localparam logic [3:0] OP_OR    = 4'h3;
   localparam logic [3:0] OP_XOR   = 4'h4;
   localparam logic [3:0] OP_SLL   = 4'h5;
   localparam logic [3:0] OP_SRL   = 4'h6;
   localparam logic [3:0] OP_SRA   = 4'h7;
   localparam logic [3:0] OP_SLT   = 4'h8;
   localparam logic [3:0] OP_SLTU  = 4'h9;
   localparam logic [3:0] OP_MUL   = 4'hA;
   localparam logic [3:0] OP_MULHU = 4'hB;

   typedef struct packed {
      logic [31:0] sdata;
      logic        mem_read;
      logic        mem_write;
      logic        reg_write;
      logic [4:0]  rd;
   } slot_ctl_t;

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      slot_ctl_t   ctl;
   } slot_in_t;

   typedef struct packed {
      logic [31:0] alu_res;
      slot_ctl_t   ctl;
   } slot_out_t;

endpackage

module dual_execute_stage
   import dual_execute_stage_pkg::*;
#(
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        in_valid,
   input  logic [3:0]  op0,
   input  logic [3:0]  op1,
   input  logic [31:0] a0,
   input  logic [31:0] b0,
   input  logic [31:0] a1,
   input  logic [31:0] b1,
   input  logic [31:0] sdata0,
   input  logic [31:0] sdata1,
   input  logic        mem_read0,
   input  logic        mem_read1,
   input  logic        mem_write0,
   input  logic        mem_write1,
   input  logic        reg_write0,
   input  logic        reg_write1,
   input  logic [4:0]  rd0,
   input  logic [4:0]  rd1,
   output logic        ex_stall,
   output logic [31:0] alu_res0,
   output logic [31:0] alu_res1,
   output logic [31:0] wdata0,
   output logic [31:0] wdata1,
   output logic        mem_read_o0,
   output logic        mem_read_o1,
   output logic        mem_write_o0,
   output logic        mem_write_o1,
   output logic        reg_write_o0,
   output logic        reg_write_o1,
   output logic [4:0]  rd_o0,
   output logic [4:0]  rd_o1,
   output logic        ex_illegal
);

   localparam int unsigned MUL_CYCLES = 32 / BITS_PER_CYCLE;
   localparam int unsigned CNT_W      = $clog2(MUL_CYCLES) + 1;
`ifdef MULHU_EN
   localparam int unsigned ACC_W      = 64;
`else
   localparam int unsigned ACC_W      = 32;
`endif

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [ACC_W-1:0]    mcand_q, mcand_d;
   logic [31:0]         mplier_q, mplier_d;
   slot_ctl_t           hold0_q, hold0_d;
   slot_in_t            hold1_q, hold1_d;
   slot_out_t           out0_q, out0_d;
   slot_out_t           out1_q, out1_d;
   logic                illegal_q, illegal_d;
   logic                ill0, ill1;
   slot_in_t            in0, in1;
   logic [ACC_W-1:0]    product;
   logic [31:0]         mul_res;

   assign in0 = {op0, a0, b0, sdata0, mem_read0, mem_write0, reg_write0, rd0};
   assign in1 = {op1, a1, b1, sdata1, mem_read1, mem_write1, reg_write1, rd1};

   function automatic logic is_mul_op(input logic [3:0] op);
`ifdef MULHU_EN
      return (op == OP_MUL) || (op == OP_MULHU);
`else
      return op == OP_MUL;
`endif
   endfunction

   // Ops that the plain ALU path executes; anything above SLTU is either a multiply or illegal.
   function automatic logic alu_legal(input logic [3:0] op);
      return op <= OP_SLTU;
   endfunction

   function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
      logic [31:0] r;
      r = '0;
      case (op)
         OP_ADD:  r = a + b;
         OP_SUB:  r = a - b;
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_SLL:  r = a << b[4:0];
         OP_SRL:  r = a >> b[4:0];
         OP_SRA:  r = 32'($signed(a) >>> b[4:0]);
         OP_SLT:  r = {31'b0, $signed(a) < $signed(b)};
         OP_SLTU: r = {31'b0, a < b};
         default: r = '0;
      endcase
      return r;
   endfunction

   // Illegal slots keep rd/wdata but lose their result and all side effects.
   function automatic slot_out_t exec(input slot_in_t s, input logic ill);
      slot_out_t o;
      o.alu_res       = ill ? 32'h0 : alu(s.op, s.a, s.b);
      o.ctl           = s.ctl;
      o.ctl.mem_read  = s.ctl.mem_read  & ~ill;
      o.ctl.mem_write = s.ctl.mem_write & ~ill;
      o.ctl.reg_write = s.ctl.reg_write & ~ill;
      return o;
   endfunction

   // One radix-2^BITS_PER_CYCLE partial product.
   function automatic logic [ACC_W-1:0] mul_step(input logic [ACC_W-1:0] mc,
                                                 input logic [BITS_PER_CYCLE-1:0] digit);
      logic [ACC_W-1:0] sum;
      sum = '0;
      for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
         if (digit[i]) sum = sum + (mc << i);
      end
      return sum;
   endfunction

   // The last digit is folded in combinationally on the accepting cycle.
   assign product = acc_q + mul_step(mcand_q, mplier_q[BITS_PER_CYCLE-1:0]);

`ifdef MULHU_EN
   logic mulhi_q, mulhi_d;
   assign mul_res = mulhi_q ? product[63:32] : product[31:0];
`else
   assign mul_res = product;
`endif

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      hold0_d   = hold0_q;
      hold1_d   = hold1_q;
      out0_d    = '0;
      out1_d    = '0;
      illegal_d = 1'b0;
      ex_stall  = 1'b0;
      ill0      = 1'b0;
      ill1      = 1'b0;
`ifdef MULHU_EN
      mulhi_d   = mulhi_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid && is_mul_op(op0)) begin
               // First digit is retired while loading so MUL_CYCLES cycles cover all 32 bits.
               ex_stall = 1'b1;
               state_d  = BUSY;
               count_d  = CNT_W'(1);
               hold0_d  = in0.ctl;
               hold1_d  = in1;
               acc_d    = mul_step(ACC_W'(a0), b0[BITS_PER_CYCLE-1:0]);
               mcand_d  = ACC_W'(a0) << BITS_PER_CYCLE;
               mplier_d = b0 >> BITS_PER_CYCLE;
`ifdef MULHU_EN
               mulhi_d  = (op0 == OP_MULHU);
`endif
            end else if (in_valid) begin
               ill0      = !alu_legal(op0);
               ill1      = !alu_legal(op1);
               out0_d    = exec(in0, ill0);
               out1_d    = exec(in1, ill1);
               illegal_d = ill0 | ill1;
            end
         end
         BUSY: begin
            if (count_q == CNT_W'(MUL_CYCLES - 1)) begin
               state_d        = IDLE;
               count_d        = '0;
               ill1           = !alu_legal(hold1_q.op);
               out0_d.alu_res = mul_res;
               out0_d.ctl     = hold0_q;
               out1_d         = exec(hold1_q, ill1);
               illegal_d      = ill1;
            end else begin
               ex_stall = 1'b1;
               count_d  = count_q + CNT_W'(1);
               acc_d    = product;
               mcand_d  = mcand_q << BITS_PER_CYCLE;
               mplier_d = mplier_q >> BITS_PER_CYCLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (flush) begin
         state_d   = IDLE;
         count_d   = '0;
         out0_d    = '0;
         out1_d    = '0;
         illegal_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // Multiplier datapath, held pair and EX/MEM register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         hold0_q   <= '0;
         hold1_q   <= '0;
         out0_q    <= '0;
         out1_q    <= '0;
         illegal_q <= 1'b0;
`ifdef MULHU_EN
         mulhi_q   <= 1'b0;
`endif
      end else begin
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         hold0_q   <= hold0_d;
         hold1_q   <= hold1_d;
         out0_q    <= out0_d;
         out1_q    <= out1_d;
         illegal_q <= illegal_d;
`ifdef MULHU_EN
         mulhi_q   <= mulhi_d;
`endif
      end
   end

   assign alu_res0     = out0_q.alu_res;
   assign wdata0       = out0_q.ctl.sdata;
   assign mem_read_o0  = out0_q.ctl.mem_read;
   assign mem_write_o0 = out0_q.ctl.mem_write;
   assign reg_write_o0 = out0_q.ctl.reg_write;
   assign rd_o0        = out0_q.ctl.rd;
   assign alu_res1     = out1_q.alu_res;
   assign wdata1       = out1_q.ctl.sdata;
   assign mem_read_o1  = out1_q.ctl.mem_read;
   assign mem_write_o1 = out1_q.ctl.mem_write;
   assign reg_write_o1 = out1_q.ctl.reg_write;
   assign rd_o1        = out1_q.ctl.rd;
   assign ex_illegal   = illegal_q;

endmodule

// File: tb/tb_dual_execute_stage.sv
// Self-checking bench for dual_execute_stage: randomized pairs against an arithmetic reference model.
module tb_dual_execute_stage;

   localparam int unsigned BPC        = 1;
   localparam int unsigned MUL_CYCLES = 32 / BPC;

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] sdata;
      logic        mr;
      logic        mw;
      logic        rw;
      logic [4:0]  rd;
   } slot_t;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic [3:0]  op0, op1;
   logic [31:0] a0, b0, a1, b1, sdata0, sdata1;
   logic        mem_read0, mem_read1, mem_write0, mem_write1, reg_write0, reg_write1;
   logic [4:0]  rd0, rd1;
   logic        ex_stall;
   logic [31:0] alu_res0, alu_res1, wdata0, wdata1;
   logic        mem_read_o0, mem_read_o1, mem_write_o0, mem_write_o1;
   logic        reg_write_o0, reg_write_o1;
   logic [4:0]  rd_o0, rd_o1;
   logic        ex_illegal;

   int errors = 0;
   int checks = 0;

   dual_execute_stage #(.BITS_PER_CYCLE(BPC)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
      .op0(op0), .op1(op1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .sdata0(sdata0), .sdata1(sdata1),
      .mem_read0(mem_read0), .mem_read1(mem_read1),
      .mem_write0(mem_write0), .mem_write1(mem_write1),
      .reg_write0(reg_write0), .reg_write1(reg_write1),
      .rd0(rd0), .rd1(rd1), .ex_stall(ex_stall),
      .alu_res0(alu_res0), .alu_res1(alu_res1), .wdata0(wdata0), .wdata1(wdata1),
      .mem_read_o0(mem_read_o0), .mem_read_o1(mem_read_o1),
      .mem_write_o0(mem_write_o0), .mem_write_o1(mem_write_o1),
      .reg_write_o0(reg_write_o0), .reg_write_o1(reg_write_o1),
      .rd_o0(rd_o0), .rd_o1(rd_o1), .ex_illegal(ex_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic bit is_mul(input logic [3:0] op);
`ifdef MULHU_EN
      return (op == 4'hA) || (op == 4'hB);
`else
      return op == 4'hA;
`endif
   endfunction

   function automatic bit ref_illegal(input logic [3:0] op, input bit slot1);
      if (op <= 4'd9) return 1'b0;
      if (op == 4'hA) return slot1;
`ifdef MULHU_EN
      if (op == 4'hB) return slot1;
`endif
      return 1'b1;
   endfunction

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] p;
      int unsigned sh;
      p  = {32'h0, a} * {32'h0, b};
      sh = int'(b % 32);
      case (op)
         4'h0: return a + b;
         4'h1: return a - b;
         4'h2: return a & b;
         4'h3: return a | b;
         4'h4: return a ^ b;
         4'h5: return a << sh;
         4'h6: return a >> sh;
         4'h7: return 32'($signed(a) >>> sh);
         4'h8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'h9: return (a < b) ? 32'd1 : 32'd0;
         4'hA: return p[31:0];
         4'hB: return p[63:32];
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [71:0] ref_slot(input slot_t s, input bit slot1);
      if (ref_illegal(s.op, slot1)) return {32'h0, s.sdata, 3'b000, s.rd};
      return {ref_alu(s.op, s.a, s.b), s.sdata, s.mr, s.mw, s.rw, s.rd};
   endfunction

   function automatic logic [144:0] ref_pair(input slot_t s0, input slot_t s1);
      return {ref_slot(s0, 1'b0), ref_slot(s1, 1'b1),
              ref_illegal(s0.op, 1'b0) | ref_illegal(s1.op, 1'b1)};
   endfunction

   function automatic logic [144:0] observed();
      return {alu_res0, wdata0, mem_read_o0, mem_write_o0, reg_write_o0, rd_o0,
              alu_res1, wdata1, mem_read_o1, mem_write_o1, reg_write_o1, rd_o1, ex_illegal};
   endfunction

   // ---------------- stimulus helpers ----------------
   function automatic slot_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      slot_t s;
      s.op    = op;
      s.a     = a;
      s.b     = b;
      s.sdata = $urandom;
      s.mr    = 1'($urandom);
      s.mw    = 1'($urandom);
      s.rw    = 1'($urandom);
      s.rd    = 5'($urandom);
      return s;
   endfunction

   function automatic slot_t rand_slot(input int unsigned max_op);
      slot_t s;
      s = mk(4'($urandom_range(0, max_op)), $urandom, $urandom);
      if ($urandom_range(0, 5) == 0) s.b = s.a;
      return s;
   endfunction

   task automatic drive(input logic v, input slot_t s0, input slot_t s1);
      in_valid = v;
      op0 = s0.op; a0 = s0.a; b0 = s0.b; sdata0 = s0.sdata;
      mem_read0 = s0.mr; mem_write0 = s0.mw; reg_write0 = s0.rw; rd0 = s0.rd;
      op1 = s1.op; a1 = s1.a; b1 = s1.b; sdata1 = s1.sdata;
      mem_read1 = s1.mr; mem_write1 = s1.mw; reg_write1 = s1.rw; rd1 = s1.rd;
   endtask

   // Issues one pair and follows it cycle by cycle until it leaves EX (or is flushed).
   task automatic issue_and_check(input slot_t s0, input slot_t s1, input int flush_at,
                                  input int drop_at, input string tag);
      int lat;
      logic [144:0] exp;
      lat = is_mul(s0.op) ? int'(MUL_CYCLES) : 1;
      exp = ref_pair(s0, s1);
      drive(1'b1, s0, s1);
      for (int k = 0; k < lat; k++) begin
         if (k == drop_at) drive(1'b0, rand_slot(15), rand_slot(15));
         #1;
         checks++;
         if (ex_stall !== 1'(k < lat - 1)) begin
            errors++;
            $display("FAIL %s stall k=%0d: got %b expected %b", tag, k, ex_stall, k < lat - 1);
         end
         flush = (k == flush_at);
         @(posedge clk);
         #1;
         flush = 1'b0;
         checks++;
         if (k == flush_at || k < lat - 1) begin
            if (observed() !== '0) begin
               errors++;
               $display("FAIL %s bubble k=%0d: got %h expected 0", tag, k, observed());
            end
         end else if (observed() !== exp) begin
            errors++;
            $display("FAIL %s result: got %h expected %h", tag, observed(), exp);
         end
         if (k == flush_at) break;
      end
      in_valid = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      slot_t s0, s1, m0;
      s0 = mk(4'h0, 32'd1, 32'd2);
      s1 = mk(4'h4, 32'hF0F0, 32'h0FF0);
      reset = 1'b0;
      flush = 1'b0;
      drive(1'b1, s0, s1);
      repeat (2) begin
         @(posedge clk);
         #1;
         checks++;
         if (observed() !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", observed());
         end
         checks++;
         if (ex_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: got %b expected 0", ex_stall);
         end
      end
      reset = 1'b1;
      issue_and_check(s0, s1, -1, -1, "reset_release");
      // reset during a multiply wins over a simultaneous flush and returns to IDLE
      m0 = mk(4'hA, $urandom, $urandom);
      drive(1'b1, m0, s1);
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b0;
      flush = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b1;
      flush = 1'b0;
      checks++;
      if (observed() !== '0) begin
         errors++;
         $display("FAIL reset_mid_mul: got %h expected 0", observed());
      end
      issue_and_check(s0, s1, -1, -1, "after_reset_mid_mul");
   endtask

   task automatic test_add_sub();
      slot_t s0, s1;
      s0 = mk(4'h0, 32'd5, 32'd7);
      s1 = mk(4'h1, 32'd3, 32'd10);
      s0.rd = 5'd0;
      issue_and_check(s0, s1, -1, -1, "add_sub");
      checks++;
      if (alu_res0 !== 32'd12 || alu_res1 !== 32'hFFFF_FFF9) begin
         errors++;
         $display("FAIL add_sub_values: got %h %h expected 0000000c fffffff9", alu_res0, alu_res1);
      end
      checks++;
      if (rd_o0 !== 5'd0 || rd_o1 !== s1.rd) begin
         errors++;
         $display("FAIL add_sub_rd: got %0d %0d expected 0 %0d", rd_o0, rd_o1, s1.rd);
      end
   endtask

   task automatic test_alu_random();
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            drive(1'b0, rand_slot(15), rand_slot(15));
            #1;
            checks++;
            if (ex_stall !== 1'b0) begin
               errors++;
               $display("FAIL idle_bubble_stall: got %b expected 0", ex_stall);
            end
            @(posedge clk);
            #1;
            checks++;
            if (observed() !== '0) begin
               errors++;
               $display("FAIL idle_bubble: got %h expected 0", observed());
            end
         end else begin
            issue_and_check(rand_slot(9), rand_slot(($urandom_range(0, 3) == 0) ? 15 : 9),
                            -1, -1, "alu_rand");
         end
      end
   endtask

   task automatic test_mul();
      slot_t s0, s1;
      s0 = mk(4'hA, 32'h0001_0000, 32'h0001_0000);
      s1 = mk(4'h3, 32'h0000_00F0, 32'h0000_000F);
      issue_and_check(s0, s1, -1, -1, "mul_2p32");
      checks++;
      if (alu_res0 !== 32'h0 || alu_res1 !== 32'hFF) begin
         errors++;
         $display("FAIL mul_2p32_values: got %h %h expected 00000000 000000ff", alu_res0, alu_res1);
      end
      for (int i = 0; i < 4; i++)
         issue_and_check(mk(4'hA, $urandom, $urandom), rand_slot(15), -1,
                         (i == 1) ? 7 : -1, "mul_rand");
      issue_and_check(mk(4'hA, 32'hFFFF_FFFF, 32'hFFFF_FFFF), rand_slot(9), -1, -1, "mul_max");
   endtask

   task automatic test_flush();
      slot_t s0, s1, add0, add1;
      s0   = mk(4'hA, 32'h0001_0000, 32'h0001_0000);
      s1   = mk(4'h3, 32'h0000_00F0, 32'h0000_000F);
      add0 = mk(4'h0, $urandom, $urandom);
      add1 = mk(4'h2, $urandom, $urandom);
      issue_and_check(s0, s1, 10, -1, "mul_flush10");
      issue_and_check(add0, add1, -1, -1, "add_after_flush");
      issue_and_check(add0, add1, 0, -1, "flush_on_accept");
      issue_and_check(mk(4'hA, $urandom, $urandom), s1, 0, -1, "flush_on_mul_load");
      issue_and_check(s0, s1, 30, -1, "mul_flush_last_busy");
      issue_and_check(rand_slot(9), rand_slot(9), -1, -1, "alu_after_flush");
   endtask

   task automatic test_illegal();
      slot_t s0, s1;
      s0 = mk(4'h0, $urandom, $urandom);
      s1 = mk(4'hA, $urandom, $urandom);
      s1.rw = 1'b1;
      s1.mr = 1'b1;
      issue_and_check(s0, s1, -1, -1, "slot1_mul");
      checks++;
      if (alu_res1 !== 32'h0 || reg_write_o1 !== 1'b0 || ex_illegal !== 1'b1) begin
         errors++;
         $display("FAIL slot1_mul_fields: got res=%h rw=%b ill=%b expected 0 0 1",
                  alu_res1, reg_write_o1, ex_illegal);
      end
      issue_and_check(rand_slot(9), rand_slot(9), -1, -1, "illegal_one_shot");
      issue_and_check(mk(4'hC, $urandom, $urandom), rand_slot(9), -1, -1, "slot0_op_c");
      issue_and_check(mk(4'hF, $urandom, $urandom), mk(4'hD, $urandom, $urandom), -1, -1,
                      "both_illegal");
   endtask

   task automatic test_mulhu();
      slot_t s0;
      s0 = mk(4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue_and_check(s0, rand_slot(9), -1, -1, "mulhu");
      checks++;
`ifdef MULHU_EN
      if (alu_res0 !== 32'hFFFF_FFFE || ex_illegal !== 1'b0) begin
         errors++;
         $display("FAIL mulhu_value: got %h ill=%b expected fffffffe 0", alu_res0, ex_illegal);
      end
`else
      if (alu_res0 !== 32'h0 || ex_illegal !== 1'b1) begin
         errors++;
         $display("FAIL mulhu_disabled: got %h ill=%b expected 00000000 1", alu_res0, ex_illegal);
      end
`endif
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 20; i++)
         issue_and_check(rand_slot(11), rand_slot(15), -1, -1, "b2b");
   endtask

   initial begin
      flush    = 1'b0;
      reset    = 1'b0;
      in_valid = 1'b0;
      test_reset();
      test_add_sub();
      test_alu_random();
      test_mul();
      test_flush();
      test_illegal();
      test_mulhu();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
